countdown_timer_ctrl: RTL

COUNTDOWN_TIMER_CTRL -- requirements
Module: countdown_timer_ctrl

---
 rtl/countdown_timer_ctrl.sv | 91 +++++++++
 1 files changed

// File: rtl/countdown_timer_ctrl.sv
// countdown_timer_ctrl: prescaled countdown timer with pause, stop and optional periodic reload
module countdown_timer_ctrl #(
  parameter int WIDTH = 4,
  parameter int PS_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_val,
  input  logic [PS_W-1:0]  prescale,
  input  logic             auto_reload,
  input  logic             start,
  input  logic             pause,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             paused,
  output logic             tc,
  output logic             done
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;
  state_t           r_state, w_state;
  logic [WIDTH-1:0] r_count, w_count, r_load, w_load;
  logic [PS_W-1:0]  r_ps, w_ps, r_pre, w_pre;
  logic             r_ar, w_ar, r_tc, w_tc, r_busy, r_paused, r_done;
  logic             w_tick;
  assign w_tick = (r_state == S_RUN) && (r_ps == r_pre);
  always_comb begin
    w_state = r_state;
    w_count = r_count;
    w_ps    = r_ps;
    w_load  = r_load;
    w_pre   = r_pre;
    w_ar    = r_ar;
    w_tc    = 1'b0;
    if (stop) begin
      if (r_state != S_IDLE) begin
        w_state = S_IDLE;
        w_count = '0;
        w_ps    = '0;
      end
    end else if (start && load_val != '0) begin
      w_state = S_RUN;
      w_count = load_val;
      w_ps    = '0;
      w_load  = load_val;
      w_pre   = prescale;
      w_ar    = auto_reload;
    end else if (r_state == S_RUN) begin
      if (pause) w_state = S_PAUSE;
      else if (w_tick) begin
        w_ps = '0;
        if (r_count == WIDTH'(1)) begin
          w_tc    = 1'b1;
          w_count = r_ar ? r_load : '0;
          w_state = r_ar ? S_RUN : S_DONE;
        end else w_count = r_count - WIDTH'(1);
      end else w_ps = r_ps + PS_W'(1);
    end else if (r_state == S_PAUSE && !pause) w_state = S_RUN;
  end
  // status flags are registered from the next state so they align with count
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_ps     <= '0;
      r_load   <= '0;
      r_pre    <= '0;
      r_ar     <= 1'b0;
      r_tc     <= 1'b0;
      r_busy   <= 1'b0;
      r_paused <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_count  <= w_count;
      r_ps     <= w_ps;
      r_load   <= w_load;
      r_pre    <= w_pre;
      r_ar     <= w_ar;
      r_tc     <= w_tc;
      r_busy   <= (w_state == S_RUN) || (w_state == S_PAUSE);
      r_paused <= w_state == S_PAUSE;
      r_done   <= w_state == S_DONE;
    end
  end
  assign count  = r_count;
  assign busy   = r_busy;
  assign paused = r_paused;
  assign tc     = r_tc;
  assign done   = r_done;
endmodule
